seq_divider: RTL and testbench

- Parametrised unsigned divider; next generation of the team's combinational power-of-two divide (shift plus mask).
- Accepts any divisor.
- Power-of-two divisors complete through a single-cycle shift/mask fast path.
- All other non-zero divisors go through an iterative restoring divider, one quotient bit per clock.
- Start/busy/done handshake so the block can sit between registered datapath stages.

---
 rtl/seq_divider.sv | 181 ++++++++++++++++++
 tb/tb_seq_divider.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Unsigned WIDTH-bit divider with a start/busy/done handshake.
//   - divisor == 0          : completes at once, quotient all ones,
//                             remainder = dividend, div_by_zero set.
//   - divisor is a power of 2: completes at once through a shift/mask path.
//   - any other divisor     : restoring division, one quotient bit per clock,
//                             result written WIDTH clocks after acceptance.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset (overrides start)
//   start        request, only looked at while ready is high
//   dividend     unsigned dividend, captured when start is accepted
//   divisor      unsigned divisor, captured when start is accepted
//   ready        high in IDLE and DONE, i.e. a start will be accepted
//   busy         high while the iterative divider is running (CALC)
//   done         one-cycle pulse, quotient/remainder valid from this cycle
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   div_by_zero  registered flag, set when the last divisor was zero
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Counter has to hold the value WIDTH itself, hence WIDTH+1.
  localparam int CW = $clog2(WIDTH + 1);
  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;

  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] rem_work, rem_work_next;
  logic [WIDTH-1:0] quo_work, quo_work_next;
  logic [WIDTH-1:0] div_reg, div_next;

  logic [WIDTH-1:0] quotient_next;
  logic [WIDTH-1:0] remainder_next;
  logic             dbz_next;

  logic             is_pow2;
  logic [KW-1:0]    pow2_idx;
  logic [WIDTH-1:0] fast_mask;

  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // Power-of-two detection for the fast path: exactly one bit set. The
  // index loop picks the highest set bit, which is the only one in that case.
  assign is_pow2 = (divisor != '0) &&
                   ((divisor & (divisor - WIDTH'(1))) == '0);

  always_comb begin
    pow2_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (divisor[i]) begin
        pow2_idx = KW'(i);
      end
    end
  end

  assign fast_mask = (WIDTH'(1) << pow2_idx) - WIDTH'(1);

  // One restoring step. Because the partial remainder is always below the
  // divisor, the shifted value is below twice the divisor and the trial
  // difference lies in [-divisor, divisor-1]. A WIDTH+1-bit subtraction is
  // therefore enough and its MSB is a reliable sign bit.
  assign shifted_rem = {rem_work, quo_work[WIDTH-1]};
  assign trial       = shifted_rem - {1'b0, div_reg};
  assign trial_neg   = trial[WIDTH];
  assign step_rem    = trial_neg ? shifted_rem[WIDTH-1:0] : trial[WIDTH-1:0];
  assign step_quo    = {quo_work[WIDTH-2:0], ~trial_neg};

  // State and datapath registers. Outputs only move when a result is
  // written, so they hold the previous answer through IDLE and CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      rem_work    <= '0;
      quo_work    <= '0;
      div_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      rem_work    <= rem_work_next;
      quo_work    <= quo_work_next;
      div_reg     <= div_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= dbz_next;
    end
  end

  // Next-state and next-datapath logic. DONE accepts a new start just like
  // IDLE so results can be streamed back to back.
  always_comb begin
    state_next     = state;
    count_next     = count;
    rem_work_next  = rem_work;
    quo_work_next  = quo_work;
    div_next       = div_reg;
    quotient_next  = quotient;
    remainder_next = remainder;
    dbz_next       = div_by_zero;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            state_next     = DONE;
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
          end else if (is_pow2) begin
            state_next     = DONE;
            quotient_next  = dividend >> pow2_idx;
            remainder_next = dividend & fast_mask;
            dbz_next       = 1'b0;
          end else begin
            state_next    = CALC;
            count_next    = CW'(WIDTH);
            rem_work_next = '0;
            quo_work_next = dividend;
            div_next      = divisor;
          end
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end

      CALC: begin
        rem_work_next = step_rem;
        quo_work_next = step_quo;
        count_next    = count - CW'(1);
        // The step taken while count is 1 is the last of WIDTH steps.
        if (count == CW'(1)) begin
          state_next     = DONE;
          quotient_next  = step_quo;
          remainder_next = step_rem;
          dbz_next       = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == CALC);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//
// Directed bench for seq_divider at WIDTH=16. A table of dividend/divisor
// pairs with hand-computed results is run through the divider, followed by
// hand-written sequences for start-during-CALC, back-to-back operation and
// reset in the middle of a division.
//
// Latency is expressed as the number of rising edges after the accepting
// edge at which done rises: 0 for the single-cycle paths, WIDTH for the
// iterative path.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               edges;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Single comparison, counted in total/bad.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Walk falling edges until done shows up. 'seen' is the number of falling
  // edges already passed since the accepting edge. Returns the number of
  // rising edges after acceptance at which done rose, and the busy count.
  task automatic waitDone(input int seen, output int edges, output int busy_cycles);
    int n;
    n = seen;
    busy_cycles = 0;
    edges = -1;
    while (edges < 0) begin
      @(negedge clk);
      n++;
      if (busy) busy_cycles++;
      if (done) begin
        edges = n - 1;
      end else if (n >= TIMEOUT) begin
        total++;
        bad++;
        $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", n);
        edges = TIMEOUT;
      end
    end
  endtask

  // Issue one operation from a falling edge and wait for its result.
  task automatic applyStimulus(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                               output int edges, output int busy_cycles);
    @(negedge clk);
    checkOutput("ready_before_start", 32'(ready), 32'd1);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(0, edges, busy_cycles);
  endtask

  task automatic runVector(input vec_t v, input int idx);
    int edges;
    int busy_cycles;
    applyStimulus(v.dvd, v.dvs, edges, busy_cycles);
    checkOutput($sformatf("v%0d_quotient", idx), 32'(quotient), 32'(v.q));
    checkOutput($sformatf("v%0d_remainder", idx), 32'(remainder), 32'(v.r));
    checkOutput($sformatf("v%0d_div_by_zero", idx), 32'(div_by_zero), 32'(v.dbz));
    checkOutput($sformatf("v%0d_latency", idx), 32'(edges), 32'(v.edges));
    checkOutput($sformatf("v%0d_busy_cycles", idx), 32'(busy_cycles),
                (v.edges == 0) ? 32'd0 : 32'(WIDTH));
    checkOutput($sformatf("v%0d_ready_at_done", idx), 32'(ready), 32'd1);
  endtask

  initial begin
    int edges;
    int busy_cycles;
    int done_count;

    //            dividend  divisor   quotient  remainder dbz edges
    vecs[0]  = '{16'd1000,  16'd8,    16'd125,  16'd0,    1'b0, 0};
    vecs[1]  = '{16'd1003,  16'd8,    16'd125,  16'd3,    1'b0, 0};
    vecs[2]  = '{16'hFFFF,  16'd1,    16'hFFFF, 16'd0,    1'b0, 0};
    vecs[3]  = '{16'd1000,  16'd7,    16'd142,  16'd6,    1'b0, 16};
    vecs[4]  = '{16'hFFFF,  16'h00FF, 16'd257,  16'd0,    1'b0, 16};
    vecs[5]  = '{16'd5,     16'd9,    16'd0,    16'd5,    1'b0, 16};
    vecs[6]  = '{16'h1234,  16'd0,    16'hFFFF, 16'h1234, 1'b1, 0};
    vecs[7]  = '{16'd10,    16'd3,    16'd3,    16'd1,    1'b0, 16};
    vecs[8]  = '{16'd0,     16'd7,    16'd0,    16'd0,    1'b0, 16};
    vecs[9]  = '{16'd0,     16'd4,    16'd0,    16'd0,    1'b0, 0};
    vecs[10] = '{16'hFFFF,  16'hFFFF, 16'd1,    16'd0,    1'b0, 16};
    vecs[11] = '{16'h8000,  16'h8000, 16'd1,    16'd0,    1'b0, 0};
    vecs[12] = '{16'd12345, 16'd100,  16'd123,  16'd45,   1'b0, 16};
    vecs[13] = '{16'd65535, 16'd3,    16'd21845, 16'd0,   1'b0, 16};
    vecs[14] = '{16'd60000, 16'h7FFF, 16'd1,    16'd27233, 1'b0, 16};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      runVector(vecs[i], i);
      @(negedge clk);
      checkOutput($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
    end

    // 100/7 with a stray start in CALC, then 50/5 back to back from DONE.
    $display("[TB] sequence: start during CALC and back-to-back");
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("ignore_busy", 32'(busy), 32'd1);
    checkOutput("ignore_ready", 32'(ready), 32'd0);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;
    waitDone(3, edges, busy_cycles);
    checkOutput("ignore_latency", 32'(edges), 32'd16);
    checkOutput("ignore_quotient", 32'(quotient), 32'd14);
    checkOutput("ignore_remainder", 32'(remainder), 32'd2);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_done_dropped", 32'(done), 32'd0);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    checkOutput("b2b_quotient_held", 32'(quotient), 32'd14);
    checkOutput("b2b_remainder_held", 32'(remainder), 32'd2);
    waitDone(1, edges, busy_cycles);
    checkOutput("b2b_latency", 32'(edges), 32'd16);
    checkOutput("b2b_quotient", 32'(quotient), 32'd10);
    checkOutput("b2b_remainder", 32'(remainder), 32'd0);
    checkOutput("b2b_div_by_zero", 32'(div_by_zero), 32'd0);

    // Reset five cycles into 1000/7 aborts it without a done pulse.
    $display("[TB] sequence: reset during CALC");
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_quotient", 32'(quotient), 32'd0);
    checkOutput("abort_remainder", 32'(remainder), 32'd0);
    checkOutput("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    done_count = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checkOutput("abort_no_done", 32'(done_count), 32'd0);
    applyStimulus(16'd1000, 16'd7, edges, busy_cycles);
    checkOutput("after_abort_latency", 32'(edges), 32'd16);
    checkOutput("after_abort_quotient", 32'(quotient), 32'd142);
    checkOutput("after_abort_remainder", 32'(remainder), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
